// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// access size encodings, controller state enum and default memory depth.
package mem_pkg;

    localparam int MEM_WORDS_DEFAULT = 129;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response handshake of the data-memory controller.
// master = pipeline issuing loads/stores, slave = the controller.
interface mem_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Little-endian lane handling: extracts and extends a byte/half for loads and
// splices store data into the addressed lane of a previously read word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val  = word[{lane, 3'b000} +: 8];
        half_val  = lane[1] ? word[31:16] : word[15:0];
        load_data = word;
        merged    = word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & byte_val[7]}}, byte_val};
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & half_val[15]}}, half_val};
                if (lane[1]) merged[31:16] = wdata;
                else         merged[15:0]  = wdata;
            end
            default: begin
                load_data = word;
                merged    = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the word-addressed data memory: byte/half/word loads and
// stores with extension, read-modify-write, error checking and handshake.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.slave  bus,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [31:0]       Address,
    output logic [31:0]       Write_data,
    input  logic [31:0]       Read_data
);

    localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

    state_t      state;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        we_q;
    logic        signed_q;
    logic [15:0] wdata_q;
    logic        ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        acc_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    // Faulty requests are decided at accept so they never touch the memory.
    always_comb begin
        acc_err = (bus.req_size == SZ_RSVD)
               || ({2'b00, bus.req_addr[31:2]} >= WORD_LIMIT)
               || (bus.req_size == SZ_HALF && bus.req_addr[0])
               || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);
    end

    mem_lane_align u_lane_align (
        .size      (size_q),
        .lane      (lane_q),
        .sign_ext  (signed_q),
        .word      (Read_data),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            wdata_q      <= 16'h0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            Address      <= 32'h0;
            Write_data   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        ready_q      <= 1'b0;
                        resp_rdata_q <= 32'h0;
                        size_q       <= bus.req_size;
                        lane_q       <= bus.req_addr[1:0];
                        we_q         <= bus.req_we;
                        signed_q     <= bus.req_signed;
                        wdata_q      <= bus.req_wdata[15:0];
                        if (acc_err) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            state        <= RESP;
                        end else begin
                            Address <= {2'b00, bus.req_addr[31:2]};
                            // Full-word stores skip the read; sub-word stores read first.
                            if (bus.req_we && bus.req_size == SZ_WORD) begin
                                Write_data <= bus.req_wdata;
                                MemWrite   <= 1'b1;
                                state      <= WR;
                            end else begin
                                MemRead <= 1'b1;
                                state   <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    MemRead <= 1'b0;
                    if (we_q) begin
                        Write_data <= merged_word;
                        MemWrite   <= 1'b1;
                        state      <= WR;
                    end else begin
                        resp_rdata_q <= load_data;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                WR: begin
                    MemWrite     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    ready_q      <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory interface in the MEM stage: takes one load/store request from the pipeline and drives the word-addressed data memory (MemRead/MemWrite/Address/Write_data/Read_data).
- Adds byte/halfword access, sign/zero extension, read-modify-write for sub-word stores, alignment/range checking and a valid/ready handshake so the pipeline can stall.

Parameters:
- MEM_WORDS, 129, number of 32-bit words in the data memory; valid word indices are 0..MEM_WORDS-1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend; ignored for stores
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  valid with resp_valid: misaligned, reserved size or out of range
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe, exactly one cycle per write
- Address  output  32  word index = {2'b00, addr[31:2]}
- Write_data  output  32  word written to memory
- Read_data  input  32  combinational read data for the current Address

Behaviour:
- Reset, asynchronous, active-low: state IDLE. Outputs: req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; MemRead=0, MemWrite=0, Address=0, Write_data=0. All request registers are cleared.
- Handshake: accept when req_valid && req_ready. Register addr, size, we, signed and wdata. req_valid is ignored outside IDLE.
- States: IDLE, RD, WR, RESP.
- Error check at accept:
  - size=11, byte-address word index >= MEM_WORDS, half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with err=1.
  - No memory strobe is raised on an error.
- Load: IDLE -> RD (MemRead=1, Address driven). Read_data is extracted and extended, then registered at the end of RD. RD -> RESP. resp_valid rises 2 cycles after accept.
- Word store: IDLE -> WR (MemWrite=1, Write_data=wdata) -> RESP. resp_valid rises 2 cycles after accept.
- Sub-word store (read-modify-write): IDLE -> RD (capture Read_data) -> WR (merged word) -> RESP. resp_valid rises 3 cycles after accept.
- Merge: only the addressed lane is replaced; all other bits come from the captured word.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE with req_ready=1. A new request is accepted the cycle after RESP at the earliest.
- Lanes, little-endian:
  - Byte lane n = addr[1:0], bits [8n+7:8n].
  - Half: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
- Extension: byte/half are sign-extended from the top bit of the lane when signed=1, otherwise zero-extended. Word loads pass through unchanged.
- Strobes: MemRead and MemWrite are decoded from registered state only, never from req_* inputs, so they are glitch-free and mutually exclusive. Address and Write_data are held stable across RD/WR.
- Reset mid-operation: an in-flight access is dropped. MemWrite deasserts immediately on rst_n low. No resp_valid is produced for the dropped request.
- Address bits [1:0] never reach the memory.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state enum;
  - MEM_WORDS default.
- One natural combinational sub-module, mem_lane_align, does lane extract + extend for loads and lane merge for stores. It is instantiated once; the controller FSM stays in mem_access_ctrl.

Test Plan:
- Memory preload MEM[5]=0x00000005. Load word, addr 0x14 -> MemRead in cycle 1, Address=5; resp_valid in cycle 2, resp_rdata=0x00000005, err=0.
- MEM[2]=0x80FF7F01:
  - lb signed addr 0x0A -> 0xFFFFFFFF;
  - lbu addr 0x0B -> 0x00000080;
  - lh signed addr 0x0A -> 0xFFFF80FF;
  - lhu addr 0x08 -> 0x00007F01.
- MEM[3]=0x11223344, sb wdata 0x000000AA addr 0x0D -> cycle 1 RD, cycle 2 single MemWrite pulse with Write_data=0x1122AA44, resp in cycle 3; readback word = 0x1122AA44.
- Errors, each giving resp_valid 1 cycle after accept with err=1, rdata=0 and no MemRead/MemWrite:
  - word load addr 0x06;
  - half store addr 0x03;
  - size=11;
  - addr 0x00000204 (index 129).
- Hold req_valid=1 through back-to-back stores to 0x00 and 0x04 -> req_ready low for 2 cycles between accepts; MEM[0] and MEM[1] are updated, each with one write pulse.
- Assert rst_n low during the WR cycle of a sub-word store -> MemWrite drops in the same cycle, no resp_valid, req_ready=1 after reset release, target word unchanged.
